hatch_seq: RTL

//   Egg-hatch game sequencer; drives the frame-index interface of the 8x8 dot-matrix driver (st, num, fail).

---
 rtl/hatch_if.sv | 27 ++
 rtl/hatch_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hatch_if.sv
// Player/display bundle for the egg-hatch sequencer.
// The sequencer takes the master side: it receives start/care (and pause when
// HATCH_PAUSE_EN is defined) and drives the display frame index st/num/fail/done.
// The slave side is the player buttons plus the dot-matrix display driver.
interface hatch_if;
    logic       start;
    logic       care;
`ifdef HATCH_PAUSE_EN
    logic       pause;
`endif
    logic       st;
    logic [3:0] num;
    logic       fail;
    logic       done;

`ifdef HATCH_PAUSE_EN
    modport master (input start, input care, input pause,
                    output st, output num, output fail, output done);
    modport slave  (output start, output care, output pause,
                    input st, input num, input fail, input done);
`else
    modport master (input start, input care,
                    output st, output num, output fail, output done);
    modport slave  (output start, output care,
                    input st, input num, input fail, input done);
`endif
endinterface

// File: rtl/hatch_seq.sv
// Egg-hatch game sequencer: turns start/care pulses into display frame indices.
// Growth stages 0..5 (with a blinking care warning, frame 11), crack frames 6/7,
// hatched frames 9/10, failure frame 8. One clock tick is one millisecond.
// Optional feature macro: HATCH_PAUSE_EN adds a pause input that freezes all timers.
module hatch_seq #(
    parameter int STAGE_MS     = 2000,
    parameter int CARE_MS      = 3000,
    parameter int FRAME_MS     = 250,
    parameter int CRACK_FRAMES = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    hatch_if.master  bus
);
    localparam int MAX_AB = (STAGE_MS > CARE_MS) ? STAGE_MS : CARE_MS;
    localparam int MAX_CD = (FRAME_MS > CRACK_FRAMES) ? FRAME_MS : CRACK_FRAMES;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_MS - 1);
    // care_cnt value whose next increment would reach CARE_MS-1 (the timeout tick)
    localparam logic [CW-1:0] CARE_TRIP  = CW'(CARE_MS - 2);
    localparam logic [CW-1:0] WARN_AT    = CW'(CARE_MS / 2);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_MS - 1);
    localparam logic [CW-1:0] CRACK_LAST = CW'(CRACK_FRAMES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GROW  = 3'd1;
    localparam logic [2:0] S_CRACK = 3'd2;
    localparam logic [2:0] S_HATCH = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    localparam logic [2:0] LAST_STAGE = 3'd5;
    localparam logic [3:0] NUM_CRACK0 = 4'd6;
    localparam logic [3:0] NUM_CRACK1 = 4'd7;
    localparam logic [3:0] NUM_FAIL   = 4'd8;
    localparam logic [3:0] NUM_HATCH0 = 4'd9;
    localparam logic [3:0] NUM_HATCH1 = 4'd10;
    localparam logic [3:0] NUM_WARN   = 4'd11;

    logic [2:0]    state_r, state_s;
    logic [2:0]    stage_r, stage_s;
    logic [CW-1:0] stage_cnt_r, stage_cnt_s;
    logic [CW-1:0] care_cnt_r, care_cnt_s;
    logic [CW-1:0] frame_cnt_r, frame_cnt_s;
    logic [CW-1:0] crack_cnt_r, crack_cnt_s;
    logic          phase_r, phase_s;
    logic          st_r, st_s;
    logic [3:0]    num_r, num_s;
    logic          fail_r, fail_s;
    logic          done_r, done_s;
    logic          pause_s;
    logic          timeout_s;
    logic          stage_wrap_s;
    logic          frame_wrap_s;

`ifdef HATCH_PAUSE_EN
    assign pause_s = bus.pause;
`else
    assign pause_s = 1'b0;
`endif

    // care beats the timeout: only a tick without care can fail the egg
    assign timeout_s    = !bus.care && (care_cnt_r == CARE_TRIP);
    assign stage_wrap_s = (stage_cnt_r == STAGE_LAST);
    assign frame_wrap_s = (frame_cnt_r == FRAME_LAST);

    // Next-state and next-output computation; priority start > pause > care > timers
    always_comb begin
        state_s     = state_r;
        stage_s     = stage_r;
        stage_cnt_s = stage_cnt_r;
        care_cnt_s  = care_cnt_r;
        frame_cnt_s = frame_cnt_r;
        crack_cnt_s = crack_cnt_r;
        phase_s     = phase_r;
        st_s        = st_r;
        num_s       = num_r;
        fail_s      = fail_r;
        done_s      = done_r;
        if (bus.start) begin
            state_s     = S_GROW;
            stage_s     = 3'd0;
            stage_cnt_s = CNT_ZERO;
            care_cnt_s  = CNT_ZERO;
            frame_cnt_s = CNT_ZERO;
            crack_cnt_s = CNT_ZERO;
            phase_s     = 1'b0;
            st_s        = 1'b1;
            num_s       = 4'd0;
            fail_s      = 1'b0;
            done_s      = 1'b0;
        end else if (pause_s) begin
            // timers and outputs hold; care still resets the neglect timer
            if ((state_r == S_GROW) && bus.care) begin
                care_cnt_s  = CNT_ZERO;
                frame_cnt_s = CNT_ZERO;
                phase_s     = 1'b0;
            end else begin
                care_cnt_s  = care_cnt_r;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    st_s  = 1'b0;
                    num_s = 4'd0;
                end
                S_GROW: begin
                    if (timeout_s) begin
                        // a simultaneous stage wrap is discarded: failure wins
                        state_s     = S_FAIL;
                        frame_cnt_s = CNT_ZERO;
                        phase_s     = 1'b0;
                        st_s        = 1'b1;
                        num_s       = NUM_FAIL;
                        fail_s      = 1'b1;
                    end else begin
                        care_cnt_s = bus.care ? CNT_ZERO : (care_cnt_r + CNT_ONE);
                        if (stage_wrap_s) begin
                            stage_cnt_s = CNT_ZERO;
                            frame_cnt_s = CNT_ZERO;
                            phase_s     = 1'b0;
                            if (stage_r == LAST_STAGE) begin
                                state_s     = S_CRACK;
                                crack_cnt_s = CNT_ZERO;
                                num_s       = NUM_CRACK0;
                            end else begin
                                stage_s = stage_r + 3'd1;
                                num_s   = {1'b0, stage_s};
                            end
                        end else begin
                            stage_cnt_s = stage_cnt_r + CNT_ONE;
                            if (care_cnt_s > WARN_AT) begin
                                // warning already running: advance the blink
                                if (frame_wrap_s) begin
                                    frame_cnt_s = CNT_ZERO;
                                    phase_s     = ~phase_r;
                                end else begin
                                    frame_cnt_s = frame_cnt_r + CNT_ONE;
                                end
                            end else begin
                                // no warning, or it starts now with the stage frame
                                frame_cnt_s = CNT_ZERO;
                                phase_s     = 1'b0;
                            end
                            num_s = ((care_cnt_s >= WARN_AT) && phase_s) ? NUM_WARN : {1'b0, stage_r};
                        end
                    end
                end
                S_CRACK: begin
                    if (frame_wrap_s) begin
                        frame_cnt_s = CNT_ZERO;
                        if (crack_cnt_r == CRACK_LAST) begin
                            state_s = S_HATCH;
                            phase_s = 1'b0;
                            num_s   = NUM_HATCH0;
                            done_s  = 1'b1;
                        end else begin
                            crack_cnt_s = crack_cnt_r + CNT_ONE;
                            phase_s     = ~phase_r;
                            num_s       = phase_s ? NUM_CRACK1 : NUM_CRACK0;
                        end
                    end else begin
                        frame_cnt_s = frame_cnt_r + CNT_ONE;
                        num_s       = phase_r ? NUM_CRACK1 : NUM_CRACK0;
                    end
                end
                S_HATCH: begin
                    if (frame_wrap_s) begin
                        frame_cnt_s = CNT_ZERO;
                        phase_s     = ~phase_r;
                    end else begin
                        frame_cnt_s = frame_cnt_r + CNT_ONE;
                    end
                    num_s  = phase_s ? NUM_HATCH1 : NUM_HATCH0;
                    done_s = 1'b1;
                end
                S_FAIL: begin
                    st_s   = 1'b1;
                    num_s  = NUM_FAIL;
                    fail_s = 1'b1;
                end
                default: begin
                    state_s = S_IDLE;
                    st_s    = 1'b0;
                    num_s   = 4'd0;
                    fail_s  = 1'b0;
                    done_s  = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            stage_r     <= 3'd0;
            stage_cnt_r <= CNT_ZERO;
            care_cnt_r  <= CNT_ZERO;
            frame_cnt_r <= CNT_ZERO;
            crack_cnt_r <= CNT_ZERO;
            phase_r     <= 1'b0;
            st_r        <= 1'b0;
            num_r       <= 4'd0;
            fail_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            stage_r     <= stage_s;
            stage_cnt_r <= stage_cnt_s;
            care_cnt_r  <= care_cnt_s;
            frame_cnt_r <= frame_cnt_s;
            crack_cnt_r <= crack_cnt_s;
            phase_r     <= phase_s;
            st_r        <= st_s;
            num_r       <= num_s;
            fail_r      <= fail_s;
            done_r      <= done_s;
        end
    end

    assign bus.st   = st_r;
    assign bus.num  = num_r;
    assign bus.fail = fail_r;
    assign bus.done = done_r;
endmodule
